scr1_pipe_fprf_sb: RTL

Parametrised floating-point register file for the SCR1 pipeline, successor to the fixed 3-read/1-write FPRF. Adds configurable FLEN (32/64) with NaN-boxing of single-precision writes, a configurable number of read ports, a second write port for long-latency FPU results (div/sqrt) with a stall handshake, a per-register busy scoreboard and a sticky FS-dirty flag. Sits between EXU/IALU-FPU issue logic and the FPU writeback path.

---
 rtl/scr1_fprf_pkg.sv | 18 +
 rtl/scr1_fprf_scoreboard.sv | 57 +++++
 rtl/scr1_pipe_fprf_sb.sv | 119 +++++++++++
 3 files changed

// File: rtl/scr1_fprf_pkg.sv
// Shared defaults, address type and single-precision NaN-boxing helper for the
// parametrised FP register file.
package scr1_fprf_pkg;

    localparam int unsigned FPRF_FLEN_DEF  = 64;
    localparam int unsigned FPRF_DEPTH_DEF = 32;
    localparam int unsigned FPRF_AW_DEF    = $clog2(FPRF_DEPTH_DEF);

    typedef logic [FPRF_AW_DEF-1:0] type_scr1_fprf_addr_e;

    localparam logic [31:0] FPRF_NANBOX = 32'hFFFF_FFFF;

    // Single-precision values stored in a 64-bit register carry an all-ones upper half
    function automatic logic [63:0] fprf_fmt64(input logic [63:0] data, input logic sp);
        return sp ? {FPRF_NANBOX, data[31:0]} : data;
    endfunction

endpackage

// File: rtl/scr1_fprf_scoreboard.sv
// Per-register busy tracking for long-latency FPU ops plus the sticky
// allocation-error flag.
module scr1_fprf_scoreboard
    import scr1_fprf_pkg::*;
#(
    parameter int unsigned DEPTH = FPRF_DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    input  logic [AW-1:0]    alloc_addr,
    input  logic             clr_req,
    input  logic [AW-1:0]    clr_addr,
    input  logic             wr_req,
    input  logic [AW-1:0]    wr_addr,
    output logic [DEPTH-1:0] busy,
    output logic             alloc_err
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_nxt;
    logic             err_q;
    logic             err_nxt;

    // Clear first so a same-cycle alloc to the same register wins
    always_comb begin
        busy_nxt = busy_q;
        err_nxt  = err_q;
        if (clr_req) begin
            busy_nxt[clr_addr] = 1'b0;
        end
        if (alloc_req) begin
            if (busy_q[alloc_addr]) begin
                err_nxt = 1'b1;
            end
            busy_nxt[alloc_addr] = 1'b1;
        end
        if (wr_req && busy_q[wr_addr]) begin
            err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            err_q  <= err_nxt;
        end
    end

    assign busy      = busy_q;
    assign alloc_err = err_q;

endmodule

// File: rtl/scr1_pipe_fprf_sb.sv
// FP register file with pipe and long-latency write ports, busy scoreboard and
// FS-dirty tracking. Define SCR1_FPRF_BYPASS_EN for same-cycle write forwarding.
module scr1_pipe_fprf_sb
    import scr1_fprf_pkg::*;
#(
    parameter int unsigned FLEN  = FPRF_FLEN_DEF,
    parameter int unsigned DEPTH = FPRF_DEPTH_DEF,
    parameter int unsigned NRD   = 3,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NRD-1:0][AW-1:0]    rd_addr_i,
    output logic [NRD-1:0][FLEN-1:0]  rd_data_o,
    output logic [NRD-1:0]            rd_busy_o,
    input  logic                      wp_req_i,
    input  logic [AW-1:0]             wp_addr_i,
    input  logic [FLEN-1:0]           wp_data_i,
    input  logic                      wp_sp_i,
    input  logic                      lw_req_i,
    input  logic [AW-1:0]             lw_addr_i,
    input  logic [FLEN-1:0]           lw_data_i,
    input  logic                      lw_sp_i,
    output logic                      lw_ack_o,
    input  logic                      alloc_req_i,
    input  logic [AW-1:0]             alloc_addr_i,
    output logic [DEPTH-1:0]          busy_o,
    output logic                      alloc_err_o,
    output logic                      fs_dirty_o,
    input  logic                      fs_clean_i
);

    logic [FLEN-1:0] regs [DEPTH];
    logic [FLEN-1:0] wp_fmt;
    logic [FLEN-1:0] lw_fmt;
    logic            wp_we;
    logic            lw_we;
    logic            alloc_ok;
    logic            dirty_q;

    // Non-power-of-two DEPTH leaves addresses with no backing register
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(DEPTH);
    endfunction

    assign wp_fmt = FLEN'(fprf_fmt64(64'(wp_data_i), wp_sp_i & (FLEN == 64)));
    assign lw_fmt = FLEN'(fprf_fmt64(64'(lw_data_i), lw_sp_i & (FLEN == 64)));

    // Pipe port always wins; a stalled long write waits for an idle pipe cycle
    assign lw_ack_o = lw_req_i & ~wp_req_i & ~rst;
    assign wp_we    = wp_req_i & addr_ok(wp_addr_i);
    assign lw_we    = lw_ack_o & addr_ok(lw_addr_i);
    assign alloc_ok = alloc_req_i & addr_ok(alloc_addr_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wp_we) begin
                regs[wp_addr_i] <= wp_fmt;
            end
            if (lw_we) begin
                regs[lw_addr_i] <= lw_fmt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dirty_q <= 1'b0;
        end else if (wp_we || lw_we) begin
            dirty_q <= 1'b1;
        end else if (fs_clean_i) begin
            dirty_q <= 1'b0;
        end
    end

    assign fs_dirty_o = dirty_q;

    scr1_fprf_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) i_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .alloc_req  (alloc_ok),
        .alloc_addr (alloc_addr_i),
        .clr_req    (lw_we),
        .clr_addr   (lw_addr_i),
        .wr_req     (wp_we),
        .wr_addr    (wp_addr_i),
        .busy       (busy_o),
        .alloc_err  (alloc_err_o)
    );

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_data_o[p] = '0;
            rd_busy_o[p] = 1'b0;
            if (addr_ok(rd_addr_i[p])) begin
                rd_data_o[p] = regs[rd_addr_i[p]];
                rd_busy_o[p] = busy_o[rd_addr_i[p]];
            end
`ifdef SCR1_FPRF_BYPASS_EN
            if (wp_we && (wp_addr_i == rd_addr_i[p])) begin
                rd_data_o[p] = wp_fmt;
            end else if (lw_we && (lw_addr_i == rd_addr_i[p])) begin
                rd_data_o[p] = lw_fmt;
                if (!(alloc_ok && (alloc_addr_i == rd_addr_i[p]))) begin
                    rd_busy_o[p] = 1'b0;
                end
            end
`endif
        end
    end

endmodule
